sprite_line_renderer: RTL and testbench
=======================================

# sprite_line_renderer

Downstream consumer of the sprite VRAM (`vram_16b_x_8_x_4096`). Accepts one sprite-line draw request at a time, reads the 128-bit sprite line from VRAM, and serialises its 16 pixels into the scanline buffer. Transparent pixels are skipped and off-screen pixels are clipped. It sits between the sprite evaluation stage, which issues requests, and the scanline line buffer, which receives pixel writes.

## Interface
- `LINE_WIDTH`, default 320: visible pixels per line; writes at x ≥ `LINE_WIDTH` are suppressed.
- `X_WIDTH`, default 9: width of x coordinates and line buffer address.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: draw request valid. Upstream holds all `req_*` stable until accepted.
- `req_ready` out 1: high only in IDLE. A handshake is `req_valid && req_ready` on a rising edge.
- `req_sprite` in 8: sprite index, 0–255.
- `req_row` in 4: row within the 16×16 sprite.
- `req_x` in X_WIDTH: screen x of the sprite's leftmost pixel.
- `req_hflip` in 1: horizontal mirror.
- `vram_read_addr` out 12: registered; value is `{sprite, row}`.
- `vram_read_data` in 128: VRAM line. Valid one cycle after the address is presented (registered BRAM read).
- `lb_write_enable` out 1: line buffer write strobe.
- `lb_write_addr` out X_WIDTH: line buffer pixel address.
- `lb_write_data` out 8: palette index.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- **States:** IDLE → FETCH → LOAD → DRAW → IDLE.
- **IDLE**
  - `req_ready`=1.
  - On handshake: latch x and hflip, load `vram_read_addr` with `{req_sprite, req_row}`, go to FETCH.
- **FETCH:** 1 cycle; the address is presented to the BRAM.
- **LOAD:** 1 cycle; capture `vram_read_data` into a 128-bit line register, clear pixel counter k, go to DRAW.
- **Pixel order:** 16-bit word i = `data[16i+15:16i]`. Pixel 2i is the low byte and pixel 2i+1 is the high byte.
  - hflip=0: slot k shows pixel k.
  - hflip=1: slot k shows pixel 15−k.
- **DRAW:** 16 cycles, k = 0..15.
  - `lb_write_addr` = x+k, truncated to X_WIDTH.
  - `lb_write_data` = selected pixel.
  - `lb_write_enable` = (pixel ≠ 0) && (x+k < `LINE_WIDTH`).
  - The compare uses X_WIDTH+1 bits, so x+k never wraps into visible range.
  - Go to IDLE after k=15. There is no early exit on clipping.
- **Output sourcing:** lb outputs are driven from registers only (line register, k, x), with no input-to-output combinational path.
- **Requests while busy:** `req_valid` outside IDLE has no effect.
- **Reset:** asynchronous in any state.
  - State returns to IDLE and any in-flight request is dropped.
  - Outputs during reset: `req_ready`=0, `busy`=0, `vram_read_addr`=0, `lb_write_enable`=0, `lb_write_addr`=0, `lb_write_data`=0.
  - `req_ready` goes to 1 on the first cycle after `reset` deasserts.

## Timing
- Handshake at edge of cycle 0.
- Cycle 1: FETCH, address stable.
- Cycle 2: LOAD.
- Cycles 3–18: DRAW; pixel k is on the lb outputs in cycle 3+k.
- Cycle 19: IDLE, `req_ready`=1.
- Throughput: one sprite line per 19 cycles; there are no back-to-back overlaps.
- `vram_read_addr` holds its value until the next handshake.

## Configuration
- `SPRITE_HFLIP_EN`
  - Defined: `req_hflip` is honoured as above.
  - Undefined: `req_hflip` is ignored, slot k always shows pixel k, and no mirror mux or hflip register is synthesised.

## Structure
- **Package `sprite_pkg`**
  - Constants: `SPRITE_LINE_W`=128, `PIXEL_W`=8, `SPRITE_W`=16, `VRAM_LINE_ADDR_W`=12.
  - State enum `sprite_render_state_t` {IDLE, FETCH, LOAD, DRAW}.
- **Sub-module `sprite_line_select`:** combinational; takes the 128-bit line, k and hflip, and returns an 8-bit pixel. All sequential logic stays in the top module.

## Test plan
- **Reset:** assert `reset` → all outputs 0 immediately. Deassert → `req_ready`=1 next cycle, `busy`=0.
- **Basic draw:** sprite 0x05, row 3, x=10, hflip=0; VRAM line 0x053 holds pixels 1..16 → `vram_read_addr`=0x053. Writes addr 10..25 with data 1..16 in cycles 3..18; `req_ready`=1 in cycle 19.
- **Transparency:** same line with even pixels = 0 → strobes only at addr 11, 13, …, 25 (8 writes). DRAW still lasts 16 cycles.
- **hflip (macro defined):** basic request with hflip=1 → addr 10 gets 16, addr 25 gets 1. Macro undefined → identical to the basic draw.
- **Clipping:** x=310, `LINE_WIDTH`=320, all pixels nonzero → writes only at 310..319 (10 strobes). x=511 → no strobes, and addr wraps to 0..14 with enable low.
- **Mid-operation reset:** assert `reset` in cycle 8 (k=5) → `lb_write_enable` drops that cycle and no further writes occur. A new request after release completes normally.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and state type for the sprite line renderer.
// Contents: VRAM line geometry, pixel width, draw-counter width and the
// renderer FSM state enum.
package sprite_pkg;

    localparam int unsigned SPRITE_LINE_W    = 128;
    localparam int unsigned PIXEL_W          = 8;
    localparam int unsigned SPRITE_W         = 16;
    localparam int unsigned VRAM_LINE_ADDR_W = 12;
    localparam int unsigned SPRITE_IDX_W     = 8;
    localparam int unsigned SPRITE_ROW_W     = 4;
    localparam int unsigned K_W              = $clog2(SPRITE_W);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        DRAW
    } sprite_render_state_t;

endpackage

// File: rtl/sprite_line_select.sv
// Combinational pixel picker for one 128-bit sprite line.
// Ports:
//   sprite_line  - 16 pixels, pixel p in bits [8p+7:8p]
//   k            - output slot 0..15
//   hflip        - mirror: slot k shows pixel 15-k
//   pixel_c      - selected 8-bit palette index
module sprite_line_select
    import sprite_pkg::*;
(
    input  logic [SPRITE_LINE_W-1:0] sprite_line,
    input  logic [K_W-1:0]           k,
    input  logic                     hflip,
    output logic [PIXEL_W-1:0]       pixel_c
);

    logic [K_W-1:0] idx_c;

    // Mirror the slot index, then pick the byte.
    always_comb begin
        idx_c   = hflip ? (K_W'(SPRITE_W - 1) - k) : k;
        pixel_c = sprite_line[idx_c*PIXEL_W +: PIXEL_W];
    end

endmodule

// File: rtl/sprite_line_renderer.sv
// Sprite line renderer: fetches one 16-pixel sprite line from VRAM and
// writes its non-transparent, on-screen pixels into the scanline buffer.
// Configuration macro: SPRITE_HFLIP_EN enables horizontal mirroring; when
// undefined, req_hflip is ignored and no mirror state is kept.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   req_*            - draw request (valid/ready, sprite, row, x, hflip)
//   vram_read_addr   - registered {sprite,row} VRAM line address
//   vram_read_data   - VRAM line, valid one cycle after the address
//   lb_write_*       - registered line buffer write port
//   busy             - high whenever not idle
module sprite_line_renderer
    import sprite_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = 320,
    parameter int unsigned X_WIDTH    = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [SPRITE_IDX_W-1:0]     req_sprite,
    input  logic [SPRITE_ROW_W-1:0]     req_row,
    input  logic [X_WIDTH-1:0]          req_x,
    input  logic                        req_hflip,
    output logic [VRAM_LINE_ADDR_W-1:0] vram_read_addr,
    input  logic [SPRITE_LINE_W-1:0]    vram_read_data,
    output logic                        lb_write_enable,
    output logic [X_WIDTH-1:0]          lb_write_addr,
    output logic [PIXEL_W-1:0]          lb_write_data,
    output logic                        busy
);

    sprite_render_state_t     state;
    logic [K_W-1:0]           k;
    logic [X_WIDTH-1:0]       x_q;
    logic [SPRITE_LINE_W-1:0] line_q;
    logic                     hflip_eff;

`ifdef SPRITE_HFLIP_EN
    logic hflip_q;
    assign hflip_eff = hflip_q;
`else
    logic unused_hflip;
    assign unused_hflip = req_hflip;
    assign hflip_eff    = 1'b0;
`endif

    logic [SPRITE_LINE_W-1:0] sel_line_c;
    logic [K_W-1:0]           next_k_c;
    logic [PIXEL_W-1:0]       next_pix_c;
    logic [X_WIDTH:0]         next_pos_c;
    logic                     next_en_c;

    // Look-ahead to the pixel shown next cycle; in LOAD the line comes
    // straight from VRAM so slot 0 is registered without an extra cycle.
    always_comb begin
        sel_line_c = line_q;
        next_k_c   = k + K_W'(1);
        if (state == LOAD) begin
            sel_line_c = vram_read_data;
            next_k_c   = '0;
        end
        // One extra bit so positions past the line end never wrap back.
        next_pos_c = (X_WIDTH+1)'(x_q) + (X_WIDTH+1)'(next_k_c);
        next_en_c  = (next_pix_c != '0) &&
                     (next_pos_c < (X_WIDTH+1)'(LINE_WIDTH));
    end

    sprite_line_select u_select (
        .sprite_line (sel_line_c),
        .k           (next_k_c),
        .hflip       (hflip_eff),
        .pixel_c     (next_pix_c)
    );

    // Renderer FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            k               <= '0;
            x_q             <= '0;
            line_q          <= '0;
`ifdef SPRITE_HFLIP_EN
            hflip_q         <= 1'b0;
`endif
            vram_read_addr  <= '0;
            req_ready       <= 1'b0;
            busy            <= 1'b0;
            lb_write_enable <= 1'b0;
            lb_write_addr   <= '0;
            lb_write_data   <= '0;
        end else begin
            lb_write_enable <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        x_q            <= req_x;
`ifdef SPRITE_HFLIP_EN
                        hflip_q        <= req_hflip;
`endif
                        vram_read_addr <= {req_sprite, req_row};
                        req_ready      <= 1'b0;
                        busy           <= 1'b1;
                        state          <= FETCH;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    line_q          <= vram_read_data;
                    k               <= '0;
                    lb_write_enable <= next_en_c;
                    lb_write_addr   <= next_pos_c[X_WIDTH-1:0];
                    lb_write_data   <= next_pix_c;
                    state           <= DRAW;
                end
                DRAW: begin
                    if (k == K_W'(SPRITE_W - 1)) begin
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        k               <= next_k_c;
                        lb_write_enable <= next_en_c;
                        lb_write_addr   <= next_pos_c[X_WIDTH-1:0];
                        lb_write_data   <= next_pix_c;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Self-checking bench for sprite_line_renderer: table of draw requests with
// hand-computed VRAM address, strobe count and first/last write, a per-cycle
// pixel model, plus hand sequences for reset behaviour.
module tb_sprite_line_renderer;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [7:0]   req_sprite;
    logic [3:0]   req_row;
    logic [8:0]   req_x;
    logic         req_hflip;
    logic [11:0]  vram_read_addr;
    logic [127:0] vram_read_data;
    logic         lb_write_enable;
    logic [8:0]   lb_write_addr;
    logic [7:0]   lb_write_data;
    logic         busy;

    int total = 0;
    int bad   = 0;

    logic [127:0] vram_line;
    logic [11:0]  vram_addr_tgt;

    sprite_line_renderer #(.LINE_WIDTH(320), .X_WIDTH(9)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_sprite      (req_sprite),
        .req_row         (req_row),
        .req_x           (req_x),
        .req_hflip       (req_hflip),
        .vram_read_addr  (vram_read_addr),
        .vram_read_data  (vram_read_data),
        .lb_write_enable (lb_write_enable),
        .lb_write_addr   (lb_write_addr),
        .lb_write_data   (lb_write_data),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Registered VRAM: only the expected line holds real data.
    always @(posedge clk)
        vram_read_data <= (vram_read_addr == vram_addr_tgt) ? vram_line : {8{16'hBEEF}};

    typedef struct {
        logic [7:0]   sprite;
        logic [3:0]   row;
        logic [8:0]   x;
        logic         hflip;
        logic         noise;
        logic [127:0] line;
        logic [11:0]  vaddr;
        int           count;
        int           first_addr;
        int           first_data;
        int           last_addr;
        int           last_data;
    } vec_t;

    localparam logic [127:0] L_INC   = 128'h100F0E0D_0C0B0A09_08070605_04030201;
    localparam logic [127:0] L_EVEN0 = 128'h10000E00_0C000A00_08000600_04000200;
    localparam logic [127:0] L_MIX   = 128'h00FF0000_12345678_9ABCDEF0_00112233;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk(name, int'(req_ready), 1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cnt, fa, fd, la, ld, p, pos, exp_en;
        logic heff;
        logic [15:0] word;
        logic [7:0]  pix;
        cnt = 0; fa = -1; fd = -1; la = -1; ld = -1;
`ifdef SPRITE_HFLIP_EN
        heff = v.hflip;
`else
        heff = 1'b0;
`endif
        vram_line     = v.line;
        vram_addr_tgt = v.vaddr;
        wait_ready($sformatf("v%0d_ready_wait", idx));
        req_valid  = 1'b1;
        req_sprite = v.sprite;
        req_row    = v.row;
        req_x      = v.x;
        req_hflip  = v.hflip;
        @(posedge clk);
        #1;
        if (v.noise) begin
            req_sprite = 8'h77;
            req_row    = 4'h1;
            req_x      = 9'd3;
        end else begin
            req_valid = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("v%0d_fetch_busy", idx), int'(busy), 1);
        chk($sformatf("v%0d_fetch_ready", idx), int'(req_ready), 0);
        chk($sformatf("v%0d_vaddr", idx), int'(vram_read_addr), int'(v.vaddr));
        @(negedge clk);
        chk($sformatf("v%0d_load_en", idx), int'(lb_write_enable), 0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            p    = heff ? 15 - k : k;
            word = v.line[16*(p/2) +: 16];
            pix  = (p % 2 == 1) ? word[15:8] : word[7:0];
            pos  = int'(v.x) + k;
            exp_en = (pix != 8'h00 && pos < 320) ? 1 : 0;
            chk($sformatf("v%0d_k%0d_en", idx, k), int'(lb_write_enable), exp_en);
            chk($sformatf("v%0d_k%0d_addr", idx, k), int'(lb_write_addr), pos % 512);
            chk($sformatf("v%0d_k%0d_data", idx, k), int'(lb_write_data), int'(pix));
            if (lb_write_enable === 1'b1) begin
                cnt++;
                if (fa < 0) begin
                    fa = int'(lb_write_addr);
                    fd = int'(lb_write_data);
                end
                la = int'(lb_write_addr);
                ld = int'(lb_write_data);
            end
            if (k == 15) req_valid = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("v%0d_end_ready", idx), int'(req_ready), 1);
        chk($sformatf("v%0d_end_busy", idx), int'(busy), 0);
        chk($sformatf("v%0d_end_en", idx), int'(lb_write_enable), 0);
        chk($sformatf("v%0d_end_vaddr", idx), int'(vram_read_addr), int'(v.vaddr));
        chk($sformatf("v%0d_count", idx), cnt, v.count);
        chk($sformatf("v%0d_first_addr", idx), fa, v.first_addr);
        chk($sformatf("v%0d_first_data", idx), fd, v.first_data);
        chk($sformatf("v%0d_last_addr", idx), la, v.last_addr);
        chk($sformatf("v%0d_last_data", idx), ld, v.last_data);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, int'(req_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_vaddr"}, int'(vram_read_addr), 0);
        chk({tag, "_en"}, int'(lb_write_enable), 0);
        chk({tag, "_addr"}, int'(lb_write_addr), 0);
        chk({tag, "_data"}, int'(lb_write_data), 0);
    endtask

    initial begin
        vecs[0] = '{sprite:8'h05, row:4'h3, x:9'd10, hflip:1'b0, noise:1'b0, line:L_INC,
                    vaddr:12'h053, count:16, first_addr:10, first_data:1, last_addr:25, last_data:16};
        vecs[1] = '{sprite:8'h05, row:4'h3, x:9'd10, hflip:1'b0, noise:1'b1, line:L_EVEN0,
                    vaddr:12'h053, count:8, first_addr:11, first_data:2, last_addr:25, last_data:16};
`ifdef SPRITE_HFLIP_EN
        vecs[2] = '{sprite:8'h05, row:4'h3, x:9'd10, hflip:1'b1, noise:1'b0, line:L_INC,
                    vaddr:12'h053, count:16, first_addr:10, first_data:16, last_addr:25, last_data:1};
`else
        vecs[2] = '{sprite:8'h05, row:4'h3, x:9'd10, hflip:1'b1, noise:1'b0, line:L_INC,
                    vaddr:12'h053, count:16, first_addr:10, first_data:1, last_addr:25, last_data:16};
`endif
        vecs[3] = '{sprite:8'hAB, row:4'hF, x:9'd310, hflip:1'b0, noise:1'b0, line:L_INC,
                    vaddr:12'hABF, count:10, first_addr:310, first_data:1, last_addr:319, last_data:10};
        vecs[4] = '{sprite:8'hFF, row:4'h0, x:9'd511, hflip:1'b0, noise:1'b0, line:L_INC,
                    vaddr:12'hFF0, count:0, first_addr:-1, first_data:-1, last_addr:-1, last_data:-1};
        vecs[5] = '{sprite:8'h00, row:4'h0, x:9'd0, hflip:1'b0, noise:1'b0, line:L_MIX,
                    vaddr:12'h000, count:12, first_addr:0, first_data:8'h33, last_addr:14, last_data:8'hFF};

        reset         = 1'b1;
        req_valid     = 1'b0;
        req_sprite    = '0;
        req_row       = '0;
        req_x         = '0;
        req_hflip     = 1'b0;
        vram_line     = '0;
        vram_addr_tgt = '0;

        // Reset: outputs zero while held, ready the cycle after release.
        #2;
        chk_all_zero("rst_hold");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_rel_ready", int'(req_ready), 1);
        chk("rst_rel_busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Mid-draw reset at k=5 (cycle 8) drops the write immediately.
        vram_line     = L_INC;
        vram_addr_tgt = 12'h053;
        wait_ready("mid_ready_wait");
        req_valid  = 1'b1;
        req_sprite = 8'h05;
        req_row    = 4'h3;
        req_x      = 9'd10;
        req_hflip  = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_k5_en", int'(lb_write_enable), 1);
        chk("mid_k5_addr", int'(lb_write_addr), 15);
        chk("mid_k5_data", int'(lb_write_data), 6);
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mid_rst_c%0d_en", c), int'(lb_write_enable), 0);
        end
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("mid_post_c%0d_en", c), int'(lb_write_enable), 0);
            chk($sformatf("mid_post_c%0d_busy", c), int'(busy), 0);
        end
        run_vec(6, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
